pc_fetch_unit: RTL and testbench

Fetch stage of the single-cycle processor: holds the program counter, drives the instruction-memory address, and presents the fetched instruction and its 4-bit `opCode` to the ALUOp decoder and the rest of the datapath. It owns the N/Z/V flag register and resolves B/BR branches and HLT, so it is the only place next-PC is computed.

---
 rtl/pc_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the program counter, the {N,Z,V} flag register and the
// RUN/HALTED state, and resolves B/BR/HLT to form the next PC each cycle.
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic [3:0]  opCode,
  output logic [15:0] pc_plus2,
  input  logic [15:0] br_target_reg,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_v,
  output logic [2:0]  flags,
  output logic        branch_taken,
  output logic        halt
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t      r_state;
  logic [15:0] r_pc;
  logic        r_flag_n;
  logic        r_flag_z;
  logic        r_flag_v;

  logic [3:0]  w_opcode;
  logic [2:0]  w_ccc;
  logic        w_running;
  logic        w_is_branch;
  logic        w_is_hlt;
  logic        w_cond_true;
  logic        w_branch_taken;
  logic [15:0] w_pc_plus2;
  logic [15:0] w_b_offset;
  logic [15:0] w_b_target;
  logic [15:0] w_next_pc;
  logic        w_wr_nv;
  logic        w_wr_z;

  assign w_opcode    = imem_data[15:12];
  assign w_ccc       = imem_data[11:9];
  assign w_running   = (r_state == ST_RUN);
  assign w_is_branch = (w_opcode == OP_B) || (w_opcode == OP_BR);
  assign w_is_hlt    = (w_opcode == OP_HLT);

  // B offset is a signed halfword count, so sign-extend and scale by two.
  assign w_pc_plus2 = r_pc + 16'd2;
  assign w_b_offset = {{6{imem_data[8]}}, imem_data[8:0], 1'b0};
  assign w_b_target = w_pc_plus2 + w_b_offset;

  // Condition is judged on the registered flags only; the current
  // instruction's ALU flags never bypass into its own branch decision.
  always_comb begin
    unique case (w_ccc)
      3'b000:  w_cond_true = !r_flag_z;
      3'b001:  w_cond_true = r_flag_z;
      3'b010:  w_cond_true = !r_flag_z && !r_flag_n;
      3'b011:  w_cond_true = r_flag_n;
      3'b100:  w_cond_true = r_flag_z || (!r_flag_z && !r_flag_n);
      3'b101:  w_cond_true = r_flag_n || r_flag_z;
      3'b110:  w_cond_true = r_flag_v;
      default: w_cond_true = 1'b1;
    endcase
  end

  assign w_branch_taken = w_running && w_is_branch && w_cond_true;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next_pc = w_pc_plus2;
    if (w_is_hlt) begin
      w_next_pc = r_pc;
    end else if (w_branch_taken) begin
      w_next_pc = (w_opcode == OP_BR) ? br_target_reg : w_b_target;
    end
  end

  always_comb begin
    w_wr_nv = 1'b0;
    w_wr_z  = 1'b0;
    unique case (w_opcode)
      OP_ADD, OP_SUB: begin
        w_wr_nv = 1'b1;
        w_wr_z  = 1'b1;
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: w_wr_z = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_pc     <= RESET_PC;
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_v <= 1'b0;
    end else if (w_running) begin
      r_pc <= w_next_pc;
      if (w_wr_nv) begin
        r_flag_n <= alu_n;
        r_flag_v <= alu_v;
      end
      if (w_wr_z) begin
        r_flag_z <= alu_z;
      end
      if (w_is_hlt) begin
        r_state <= ST_HALTED;
      end
    end
  end

  assign imem_addr    = r_pc;
  assign instr        = imem_data;
  assign opCode       = w_opcode;
  assign pc_plus2     = w_pc_plus2;
  assign flags        = {r_flag_n, r_flag_z, r_flag_v};
  assign branch_taken = w_branch_taken;
  // Combinational so the HLT instruction's own cycle already reports halt.
  assign halt         = !w_running || w_is_hlt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized and directed bench for pc_fetch_unit: a driver pushes expected
// outputs from an architectural model into a queue, a monitor pops and compares.
module tb_pc_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] instr;
  logic [3:0]  opCode;
  logic [15:0] pc_plus2;
  logic [15:0] br_target_reg = 16'h0000;
  logic        alu_n = 1'b0;
  logic        alu_z = 1'b0;
  logic        alu_v = 1'b0;
  logic [2:0]  flags;
  logic        branch_taken;
  logic        halt;

  pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr(instr), .opCode(opCode), .pc_plus2(pc_plus2),
    .br_target_reg(br_target_reg), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .flags(flags), .branch_taken(branch_taken), .halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] pc2;
    logic [15:0] ins;
    logic [3:0]  op;
    logic [2:0]  flg;
    logic        hlt;
    logic        bt;
    int          idx;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_cycles = 0;

  // Architectural model state.
  logic [15:0] m_pc = RESET_PC;
  bit          m_n = 0, m_z = 0, m_v = 0;
  bit          m_halted = 0;

  task automatic check(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, idx, act, req);
    end
  endtask

  function automatic bit cond_ok(input logic [2:0] c);
    case (c)
      3'd0: return !m_z;                 // NE
      3'd1: return m_z;                  // EQ
      3'd2: return !m_z && !m_n;         // GT
      3'd3: return m_n;                  // LT
      3'd4: return m_z || (!m_z && !m_n);// GTE
      3'd5: return m_n || m_z;           // LTE
      3'd6: return m_v;                  // OVFL
      default: return 1'b1;
    endcase
  endfunction

  // One processor cycle: drive inputs, record expected outputs, advance model.
  task automatic cyc(input logic [15:0] ins, input logic [15:0] brt,
                     input logic [2:0] nzv, input logic rst, input bit chk);
    exp_t e;
    logic [3:0] op;
    bit         is_br, taken;
    int         off;
    @(posedge clk);
    #1;
    imem_data = ins;
    br_target_reg = brt;
    {alu_n, alu_z, alu_v} = nzv;
    rst_n = rst;
    n_cycles++;

    op    = ins[15:12];
    is_br = (op == 4'hC) || (op == 4'hD);
    taken = !m_halted && is_br && cond_ok(ins[11:9]);
    e.pc  = m_pc;
    e.pc2 = m_pc + 16'd2;
    e.ins = ins;
    e.op  = op;
    e.flg = {m_n, m_z, m_v};
    e.hlt = m_halted || (op == 4'hF);
    e.bt  = taken;
    e.idx = n_cycles;
    if (chk) sb.push_back(e);

    if (!rst) begin
      m_pc = RESET_PC;
      {m_n, m_z, m_v} = 3'b000;
      m_halted = 0;
    end else if (!m_halted) begin
      if (op == 4'hF) begin
        m_halted = 1;
      end else if (taken && op == 4'hD) begin
        m_pc = brt;
      end else if (taken) begin
        off = ins[8] ? int'(ins[8:0]) - 512 : int'(ins[8:0]);
        m_pc = 16'(int'(m_pc) + 2 + 2 * off);
      end else begin
        m_pc = m_pc + 16'd2;
      end
      if (op == 4'h0 || op == 4'h1) begin
        {m_n, m_z, m_v} = nzv;
      end else if (op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h6) begin
        m_z = nzv[1];
      end
    end
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the queue.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("imem_addr", e.idx, imem_addr, e.pc);
      check("pc_plus2", e.idx, pc_plus2, e.pc2);
      check("instr", e.idx, instr, e.ins);
      check("opCode", e.idx, {12'h0, opCode}, {12'h0, e.op});
      check("flags", e.idx, {13'h0, flags}, {13'h0, e.flg});
      check("halt", e.idx, {15'h0, halt}, {15'h0, e.hlt});
      check("branch_taken", e.idx, {15'h0, branch_taken}, {15'h0, e.bt});
    end
  end

  localparam logic [15:0] I_ADD = 16'h0000;
  localparam logic [15:0] I_SUB = 16'h1000;
  localparam logic [15:0] I_XOR = 16'h2000;
  localparam logic [15:0] I_LW  = 16'h8000;
  localparam logic [15:0] I_HLT = 16'hF000;
  localparam logic [15:0] I_BR_ALWAYS = 16'hDE00;
  localparam logic [15:0] I_B_EQ_M2   = 16'hC3FE;
  localparam logic [15:0] I_B_ALWAYS  = 16'hCE10;

  initial begin
    logic [3:0]  op;
    logic [15:0] ins;
    logic        rst;
    int          halted_for;

    // Reset held for two cycles, then sequential ADDs.
    cyc(I_ADD, 16'h0, 3'b000, 1'b0, 1'b0);
    cyc(I_ADD, 16'h0, 3'b000, 1'b0, 1'b1);
    repeat (3) cyc(I_ADD, 16'h0, 3'b000, 1'b1, 1'b1);

    // Flag write enables.
    cyc(I_SUB, 16'h0, 3'b011, 1'b1, 1'b1);
    cyc(I_XOR, 16'h0, 3'b100, 1'b1, 1'b1);
    cyc(I_LW,  16'h0, 3'b111, 1'b1, 1'b1);
    cyc(I_ADD, 16'h0, 3'b010, 1'b1, 1'b1);

    // B EQ -2 at 0x0010 taken with Z=1, then not taken with Z=0.
    cyc(I_BR_ALWAYS, 16'h0010, 3'b000, 1'b1, 1'b1);
    cyc(I_B_EQ_M2, 16'h0, 3'b000, 1'b1, 1'b1);
    cyc(I_ADD, 16'h0, 3'b000, 1'b1, 1'b1);
    cyc(I_B_EQ_M2, 16'h0, 3'b000, 1'b1, 1'b1);
    cyc(I_BR_ALWAYS, 16'h1234, 3'b000, 1'b1, 1'b1);
    cyc(I_ADD, 16'h0, 3'b000, 1'b1, 1'b1);

    // BR condition sweep over all flag combinations.
    for (int f = 0; f < 8; f++) begin
      cyc(I_ADD, 16'h0, 3'(f), 1'b1, 1'b1);
      for (int c = 0; c < 8; c++) begin
        cyc({4'hD, 3'(c), 9'h0}, 16'($urandom), 3'($urandom), 1'b1, 1'b1);
      end
    end

    // HLT at 0x0020, sticky for 10 cycles regardless of incoming words.
    cyc(I_SUB, 16'h0, 3'b101, 1'b1, 1'b1);
    cyc(I_BR_ALWAYS, 16'h0020, 3'b000, 1'b1, 1'b1);
    cyc(I_HLT, 16'h0, 3'b010, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cyc((k % 2 == 0) ? I_HLT : I_B_ALWAYS, 16'h4444, 3'b010, 1'b1, 1'b1);
    end
    cyc(I_ADD, 16'h0, 3'b000, 1'b0, 1'b1);
    cyc(I_ADD, 16'h0, 3'b000, 1'b1, 1'b1);

    // Wrap at 0xFFFE, then reset during a taken B.
    cyc(I_BR_ALWAYS, 16'hFFFE, 3'b000, 1'b1, 1'b1);
    cyc(I_ADD, 16'h0, 3'b000, 1'b1, 1'b1);
    cyc(I_ADD, 16'h0, 3'b000, 1'b1, 1'b1);
    cyc(I_B_ALWAYS, 16'h0, 3'b111, 1'b0, 1'b1);
    cyc(I_ADD, 16'h0, 3'b000, 1'b1, 1'b1);

    // Random instruction stream with occasional HLT and reset.
    halted_for = 0;
    for (int k = 0; k < 2000; k++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'h0;
      ins = {op, 12'($urandom)};
      rst = ($urandom_range(0, 63) != 0);
      if (m_halted) begin
        halted_for++;
        if (halted_for > 4) rst = 1'b0;
      end else begin
        halted_for = 0;
      end
      cyc(ins, 16'($urandom), 3'($urandom), rst, 1'b1);
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
